mmio_bridge_n: RTL and testbench

- Parametrised successor to the CPU system bridge; sits between the MEM stage and memory/peripherals.
- DM and IM accesses pass through with zero wait states.
- Accesses to NSLV memory-mapped slaves (timers, UART, ...) run through a registered request/acknowledge FSM, with optional timeout-to-bus-error.
- Aggregates slave IRQs and a synchronised external interrupt into HWInt[5:0] for CP0.

---
 rtl/mmio_bridge_n.sv | 244 ++++++++++++++++++++++++
 tb/tb_mmio_bridge_n.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge_n.sv
// MEM-stage bridge: zero-wait DM/IM pass-through plus a request/ack FSM for NSLV MMIO slaves.
// Define MMIO_BRIDGE_TIMEOUT_EN to turn a silent slave into a bus error after TIMEOUT cycles.
module mmio_bridge_n #(
  parameter int unsigned NSLV       = 2,
  parameter logic [31:0] SLV_BASE   = 32'h0000_7F00,
  parameter logic [31:0] SLV_STRIDE = 32'h10,
  parameter logic [31:0] SLV_SPAN   = 32'hC,
  parameter logic [31:0] DM_TOP     = 32'h0000_2FFF,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_TOP     = 32'h0000_6FFF,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic [31:0]          cpu_addr,
  input  logic [3:0]           cpu_byteen,
  input  logic [31:0]          cpu_wdata,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_err,
  output logic [3:0]           dm_byteen,
  input  logic [31:0]          dm_rdata,
  input  logic [31:0]          im_rdata,
  output logic [NSLV-1:0]      slv_sel,
  output logic                 slv_we,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wdata,
  input  logic [32*NSLV-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_ack,
  input  logic [NSLV-1:0]      slv_irq,
  input  logic                 ext_int,
  output logic [5:0]           hwint
);

  if (NSLV < 1 || NSLV > 5 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mmio_bridge_n: NSLV must be 1..5 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NSLV-1:0]   sel_q, sel_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ext_s1_q, ext_s2_q;

`ifdef MMIO_BRIDGE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0]     cnt_q, cnt_d;
`endif

  logic              dm_hit;
  logic              im_hit;
  logic [NSLV-1:0]   slv_hit;
  logic              slv_any;
  logic              ack_hit;
  logic [31:0]       sel_rdata;

  function automatic logic slv_match(
    input logic [31:0] a,
    input int unsigned k
  );
    logic [31:0] b;
    b = SLV_BASE + SLV_STRIDE * k;
    return (a >= b) && ((a - b) < SLV_SPAN);
  endfunction

  // DM beats IM beats the lowest-numbered matching slave.
  always_comb begin
    dm_hit  = cpu_addr <= DM_TOP;
    im_hit  = !dm_hit && (cpu_addr >= IM_BASE) &&
              (cpu_addr <= IM_TOP);
    slv_hit = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (slv_match(cpu_addr, k) && slv_hit == '0) begin
        slv_hit[k] = 1'b1;
      end
    end
    if (dm_hit || im_hit) begin
      slv_hit = '0;
    end
    slv_any = |slv_hit;
  end

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q[k]) begin
        sel_rdata |= slv_rdata[32*k +: 32];
      end
    end
    ack_hit = |(slv_ack & sel_q);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_req && slv_any) begin
          state_d = ACCESS;
          sel_d   = slv_hit;
          we_d    = |cpu_byteen;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          state_d = DONE;
          sel_d   = '0;
          we_d    = 1'b0;
          rdata_d = sel_rdata;
          err_d   = 1'b0;
        end
`ifdef MMIO_BRIDGE_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          sel_d   = '0;
          we_d    = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ext_s1_q <= 1'b0;
      ext_s2_q <= 1'b0;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ext_s1_q <= ext_int;
      ext_s2_q <= ext_s1_q;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Ready is gated by reset so a stalled pipeline never sees a phantom completion.
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    cpu_err   = 1'b0;
    dm_byteen = '0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          if (!cpu_req) begin
            cpu_ready = 1'b1;
          end else begin
            unique case (1'b1)
              dm_hit: begin
                cpu_ready = 1'b1;
                cpu_rdata = dm_rdata;
                dm_byteen = cpu_byteen;
              end
              im_hit: begin
                cpu_ready = 1'b1;
                cpu_rdata = im_rdata;
              end
              slv_any: begin
                cpu_ready = 1'b0;
              end
              default: begin
                cpu_ready = 1'b1;
                cpu_err   = 1'b1;
              end
            endcase
          end
        end
        DONE: begin
          cpu_ready = 1'b1;
          cpu_rdata = rdata_q;
          cpu_err   = err_q;
        end
        default: begin
          cpu_ready = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    hwint          = '0;
    hwint[NSLV-1:0] = slv_irq;
    hwint[NSLV]    = ext_s2_q;
  end

  assign slv_sel   = sel_q;
  assign slv_we    = we_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_bridge_n.sv
// Randomised bench for mmio_bridge_n: acts as DM, IM and two slaves,
// and checks the CPU-side view against an address-map reference model.
module tb_mmio_bridge_n;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_rdata;
  logic [31:0] im_rdata;
  logic [1:0]  slv_sel;
  logic        slv_we;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [63:0] slv_rdata;
  logic [1:0]  slv_ack;
  logic [1:0]  slv_irq;
  logic        ext_int;
  logic [5:0]  hwint;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] dm_mem [16];
  logic [31:0] ref_dm [16];
  logic [31:0] smem   [2][4];
  logic [31:0] ref_s  [2][4];

  localparam logic [31:0] IM_KEY = 32'hA5A5_5A5A;

  mmio_bridge_n dut (
    .clk        (clk),
    .reset      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_byteen (cpu_byteen),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .dm_byteen  (dm_byteen),
    .dm_rdata   (dm_rdata),
    .im_rdata   (im_rdata),
    .slv_sel    (slv_sel),
    .slv_we     (slv_we),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .slv_rdata  (slv_rdata),
    .slv_ack    (slv_ack),
    .slv_irq    (slv_irq),
    .ext_int    (ext_int),
    .hwint      (hwint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_rdata = dm_mem[cpu_addr[5:2]];
  assign im_rdata = cpu_addr ^ IM_KEY;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (dm_byteen[b]) begin
        dm_mem[cpu_addr[5:2]][8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // -2 DM, -3 IM, -1 unmapped, else slave index
  function automatic int classify(input logic [31:0] a);
    if (a <= 32'h2FFF) return -2;
    if (a >= 32'h3000 && a <= 32'h6FFF) return -3;
    for (int k = 0; k < 2; k++) begin
      if (a >= 32'h7F00 + 16 * k && a < 32'h7F00 + 16 * k + 12)
        return k;
    end
    return -1;
  endfunction

  task automatic do_access(
    input logic [31:0] a,
    input logic [3:0]  be,
    input logic [31:0] wd,
    input int          lat
  );
    int k;
    logic [31:0] exp;
    k = classify(a);
    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_addr   = a;
    cpu_byteen = be;
    cpu_wdata  = wd;
    #1;
    if (k == -2) begin
      chk("dm_rdy", cpu_ready, 1);
      chk("dm_err", cpu_err, 0);
      chk("dm_be", dm_byteen, be);
      if (be == 4'h0) begin
        chk("dm_rd", cpu_rdata, ref_dm[a[5:2]]);
      end
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_dm[a[5:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end else if (k == -3) begin
      chk("im_rdy", cpu_ready, 1);
      chk("im_err", cpu_err, 0);
      chk("im_be", dm_byteen, 0);
      if (be == 4'h0) chk("im_rd", cpu_rdata, a ^ IM_KEY);
    end else if (k == -1) begin
      chk("un_rdy", cpu_ready, 1);
      chk("un_err", cpu_err, 1);
      chk("un_rd", cpu_rdata, 0);
      chk("un_be", dm_byteen, 0);
      chk("un_sel", slv_sel, 0);
    end else begin
      exp = ref_s[k][a[3:2]];
      chk("s_rdy0", cpu_ready, 0);
      chk("s_sel0", slv_sel, 0);
      for (int n = 1; n <= lat; n++) begin
        @(negedge clk);
        slv_ack = '0;
        #1;
        chk("s_rdyw", cpu_ready, 0);
        chk("s_sel", slv_sel, 32'(2'b01 << k));
        chk("s_we", slv_we, be != 0);
        chk("s_addr", slv_addr, a);
        if (be != 0) chk("s_wd", slv_wdata, wd);
        if (n == lat) begin
          slv_rdata[k*32 +: 32] = smem[k][slv_addr[3:2]];
          if (slv_we && slv_sel[k]) smem[k][slv_addr[3:2]] = slv_wdata;
          slv_ack[k] = 1'b1;
        end else if ($urandom_range(0, 1) == 1) begin
          slv_rdata[(1-k)*32 +: 32] = $urandom;
          slv_ack[1-k] = 1'b1;
        end
      end
      @(negedge clk);
      slv_ack = '0;
      #1;
      chk("s_rdy", cpu_ready, 1);
      chk("s_err", cpu_err, 0);
      chk("s_seld", slv_sel, 0);
      if (be == 4'h0) chk("s_rd", cpu_rdata, exp);
      else ref_s[k][a[3:2]] = wd;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 32'hBFF)) << 2;
      1: return 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
      2: return 32'h7F00 + 32'($urandom_range(0, 1)) * 16 +
                4 * 32'($urandom_range(0, 2));
      default: return $urandom_range(0, 1) ? 32'h7000 +
                32'($urandom_range(0, 32'hEFF)) : 32'h8000 + $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    int          n;
    logic        seen;
    for (int i = 0; i < 16; i++) begin
      dm_mem[i] = '0;
      ref_dm[i] = '0;
    end
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 4; w++) begin
        smem[k][w]  = '0;
        ref_s[k][w] = '0;
      end
    end
    smem[1][1]  = 32'h1234_5678;
    ref_s[1][1] = 32'h1234_5678;
    rst_n      = 1'b0;
    cpu_req    = 1'b1;
    cpu_addr   = 32'h10;
    cpu_byteen = 4'h0;
    cpu_wdata  = '0;
    slv_rdata  = '0;
    slv_ack    = '0;
    slv_irq    = '0;
    ext_int    = 1'b0;
    #12;
    chk("rst_rdy", cpu_ready, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_sel", slv_sel, 0);
    chk("rst_we", slv_we, 0);
    chk("rst_hw", hwint, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_access(32'h10, 4'hF, 32'hDEAD_BEEF, 1);
    do_access(32'h10, 4'h0, 32'h0, 1);
    do_access(32'h7F14, 4'h0, 32'h0, 2);
    do_access(32'h7F0C, 4'h0, 32'h0, 1);
    do_access(32'h8000, 4'h0, 32'h0, 1);
    do_access(32'h2FFC, 4'h3, 32'hCAFE_F00D, 1);
    do_access(32'h2FFC, 4'h0, 32'h0, 1);
    do_access(32'h3000, 4'h0, 32'h0, 1);
    do_access(32'h6FFC, 4'hF, 32'h1111_2222, 1);
    do_access(32'h7000, 4'h0, 32'h0, 1);
    do_access(32'h7F0B, 4'h0, 32'h0, 1);
    do_access(32'h7F1C, 4'h0, 32'h0, 1);
    do_access(32'h7F20, 4'h0, 32'h0, 1);
    do_access(32'hFFFF_FFFF, 4'h0, 32'h0, 1);

    for (int i = 0; i < 80; i++) begin
      a  = rand_addr();
      be = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
      do_access(a, be, $urandom, $urandom_range(1, 6));
    end

    // Slave 0 that never acknowledges
    @(negedge clk);
    cpu_addr   = 32'h7F04;
    cpu_byteen = 4'h0;
    n    = 0;
    seen = 1'b0;
    while (n < 120 && !seen) begin
      @(negedge clk);
      n++;
      #1;
      seen = cpu_ready;
    end
`ifdef MMIO_BRIDGE_TIMEOUT_EN
    chk("to_cyc", n, 16);
    chk("to_err", cpu_err, 1);
    chk("to_rd", cpu_rdata, 0);
`else
    chk("stuck", seen, 0);
    chk("stuck_sel", slv_sel, 2'b01);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("to_rsel", slv_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset on the second ACCESS cycle
    @(negedge clk);
    cpu_addr = 32'h7F18;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_sel", slv_sel, 0);
    chk("mid_we", slv_we, 0);
    chk("mid_rdy", cpu_ready, 0);
    cpu_addr = 32'h10;
    #1;
    chk("mid_dmrdy", cpu_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rdy", cpu_ready, 1);
    chk("post_rd", cpu_rdata, ref_dm[4]);
    @(negedge clk);
    cpu_req = 1'b0;

    // Interrupt aggregation and synchroniser delay
    slv_irq = 2'b01;
    #1;
    chk("irq0", hwint, 6'b000001);
    @(negedge clk);
    ext_int = 1'b1;
    #1;
    chk("ext0", hwint, 6'b000001);
    @(negedge clk);
    #1;
    chk("ext1", hwint, 6'b000001);
    @(negedge clk);
    #1;
    chk("ext2", hwint, 6'b000101);
    slv_irq = 2'b10;
    #1;
    chk("irq1", hwint, 6'b000110);
    rst_n = 1'b0;
    #1;
    chk("ext_rst", hwint, 6'b000010);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ext_r1", hwint, 6'b000010);
    @(negedge clk);
    #1;
    chk("ext_r2", hwint, 6'b000110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
